// File: rtl/rf_write_arbiter.sv
// Write-back arbiter in front of the 2-write-port register-file RAM: per-source FIFOs,
// round-robin dual issue, and suppression of same-address writes on both ports.
module rf_write_arbiter #(
    parameter int unsigned P_NUM_SRC      = 3,
    parameter int unsigned P_MEM_DEPTH    = 2048,
    parameter int unsigned P_MEM_WIDTH    = 32,
    parameter int unsigned P_FIFO_DEPTH   = 2,
    localparam int unsigned LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [P_NUM_SRC-1:0]                  src_valid_i,
    output logic [P_NUM_SRC-1:0]                  src_ready_o,
    input  logic [P_NUM_SRC*LP_INDEX_WIDTH-1:0]   src_addr_i,
    input  logic [P_NUM_SRC*P_MEM_WIDTH-1:0]      src_data_i,
    output logic                                  wra_valid_o,
    output logic [LP_INDEX_WIDTH-1:0]             wra_addr_o,
    output logic [P_MEM_WIDTH-1:0]                wra_data_o,
    output logic                                  wrb_valid_o,
    output logic [LP_INDEX_WIDTH-1:0]             wrb_addr_o,
    output logic [P_MEM_WIDTH-1:0]                wrb_data_o,
    output logic                                  busy_o
);

    localparam int unsigned LP_PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int unsigned LP_CNT_W = LP_PTR_W + 1;
    localparam int unsigned LP_RR_W  = $clog2(P_NUM_SRC);

    logic [LP_INDEX_WIDTH-1:0] addr_mem [P_NUM_SRC][P_FIFO_DEPTH];
    logic [P_MEM_WIDTH-1:0]    data_mem [P_NUM_SRC][P_FIFO_DEPTH];

    logic [LP_PTR_W-1:0]       wr_ptr_q [P_NUM_SRC];
    logic [LP_PTR_W-1:0]       wr_ptr_d [P_NUM_SRC];
    logic [LP_PTR_W-1:0]       rd_ptr_q [P_NUM_SRC];
    logic [LP_PTR_W-1:0]       rd_ptr_d [P_NUM_SRC];
    logic [LP_CNT_W-1:0]       count_q  [P_NUM_SRC];
    logic [LP_CNT_W-1:0]       count_d  [P_NUM_SRC];
    logic [LP_INDEX_WIDTH-1:0] head_addr [P_NUM_SRC];
    logic [P_MEM_WIDTH-1:0]    head_data [P_NUM_SRC];

    logic [P_NUM_SRC-1:0] ready_q, ready_d, push, pop, nonempty;
    logic [LP_RR_W-1:0]   rr_q, rr_d;
    logic [LP_RR_W-1:0]   grant_a_idx, grant_b_idx;
    logic                 grant_a_vld, grant_b_vld, issue_b;

    logic                      wra_valid_q, wra_valid_d, wrb_valid_q, wrb_valid_d;
    logic [LP_INDEX_WIDTH-1:0] wra_addr_q, wra_addr_d, wrb_addr_q, wrb_addr_d;
    logic [P_MEM_WIDTH-1:0]    wra_data_q, wra_data_d, wrb_data_q, wrb_data_d;

    function automatic logic [LP_RR_W-1:0] wrap_idx(input int unsigned base,
                                                     input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= P_NUM_SRC) s = s - P_NUM_SRC;
        return LP_RR_W'(s);
    endfunction

    always_comb begin
        push     = '0;
        nonempty = '0;
        for (int k = 0; k < P_NUM_SRC; k++) begin
            push[k]      = src_valid_i[k] & ready_q[k];
            nonempty[k]  = count_q[k] != '0;
            head_addr[k] = addr_mem[k][rd_ptr_q[k]];
            head_data[k] = data_mem[k][rd_ptr_q[k]];
        end
    end

    // Scan from rr: first non-empty head takes port A, the next one port B.
    always_comb begin
        grant_a_vld = 1'b0;
        grant_b_vld = 1'b0;
        grant_a_idx = '0;
        grant_b_idx = '0;
        for (int i = 0; i < P_NUM_SRC; i++) begin
            if (nonempty[wrap_idx(int'(rr_q), i)]) begin
                if (!grant_a_vld) begin
                    grant_a_vld = 1'b1;
                    grant_a_idx = wrap_idx(int'(rr_q), i);
                end else if (!grant_b_vld) begin
                    grant_b_vld = 1'b1;
                    grant_b_idx = wrap_idx(int'(rr_q), i);
                end
            end
        end
        issue_b = grant_b_vld && (head_addr[grant_b_idx] != head_addr[grant_a_idx]);

        pop = '0;
        if (grant_a_vld) pop[grant_a_idx] = 1'b1;
        if (issue_b)     pop[grant_b_idx] = 1'b1;

        rr_d = rr_q;
        if (issue_b)          rr_d = wrap_idx(int'(grant_b_idx), 1);
        else if (grant_a_vld) rr_d = wrap_idx(int'(grant_a_idx), 1);

        wra_valid_d = grant_a_vld;
        wra_addr_d  = grant_a_vld ? head_addr[grant_a_idx] : '0;
        wra_data_d  = grant_a_vld ? head_data[grant_a_idx] : '0;
        wrb_valid_d = issue_b;
        wrb_addr_d  = issue_b ? head_addr[grant_b_idx] : '0;
        wrb_data_d  = issue_b ? head_data[grant_b_idx] : '0;
    end

    // Ready follows the post-edge count, so a full FIFO reopens only after a real pop.
    always_comb begin
        ready_d = '0;
        for (int k = 0; k < P_NUM_SRC; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + LP_PTR_W'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + LP_PTR_W'(pop[k]);
            count_d[k]  = count_q[k] + LP_CNT_W'(push[k]) - LP_CNT_W'(pop[k]);
            ready_d[k]  = count_d[k] != LP_CNT_W'(P_FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < P_NUM_SRC; k++) begin
            if (push[k]) begin
                addr_mem[k][wr_ptr_q[k]] <= src_addr_i[k*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
                data_mem[k][wr_ptr_q[k]] <= src_data_i[k*P_MEM_WIDTH +: P_MEM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < P_NUM_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            ready_q     <= '0;
            rr_q        <= '0;
            wra_valid_q <= 1'b0;
            wra_addr_q  <= '0;
            wra_data_q  <= '0;
            wrb_valid_q <= 1'b0;
            wrb_addr_q  <= '0;
            wrb_data_q  <= '0;
        end else begin
            for (int k = 0; k < P_NUM_SRC; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
            ready_q     <= ready_d;
            rr_q        <= rr_d;
            wra_valid_q <= wra_valid_d;
            wra_addr_q  <= wra_addr_d;
            wra_data_q  <= wra_data_d;
            wrb_valid_q <= wrb_valid_d;
            wrb_addr_q  <= wrb_addr_d;
            wrb_data_q  <= wrb_data_d;
        end
    end

    assign src_ready_o = ready_q;
    assign wra_valid_o = wra_valid_q;
    assign wra_addr_o  = wra_addr_q;
    assign wra_data_o  = wra_data_q;
    assign wrb_valid_o = wrb_valid_q;
    assign wrb_addr_o  = wrb_addr_q;
    assign wrb_data_o  = wrb_data_q;
    assign busy_o      = (|nonempty) | wra_valid_q | wrb_valid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single/dual issue, conflict, backpressure,
// fairness and mid-stream reset, with hand-computed expectations.
module tb_rf_write_arbiter;

    localparam int unsigned NS = 3;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS-1:0]   src_valid = '0;
    logic [NS-1:0]   src_ready;
    logic [NS*AW-1:0] src_addr = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic            wra_valid, wrb_valid, busy;
    logic [AW-1:0]   wra_addr, wrb_addr;
    logic [DW-1:0]   wra_data, wrb_data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ram_model [2048];
    logic [AW-1:0] wa_addr_q [$];
    logic [DW-1:0] wa_data_q [$];
    int            nwrites = 0;
    int            both_cnt = 0;
    int            src_cnt [4];
    logic          win_en = 1'b0;

    rf_write_arbiter #(
        .P_NUM_SRC   (NS),
        .P_MEM_DEPTH (2048),
        .P_MEM_WIDTH (DW),
        .P_FIFO_DEPTH(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_addr_i (src_addr),
        .src_data_i (src_data),
        .wra_valid_o(wra_valid),
        .wra_addr_o (wra_addr),
        .wra_data_o (wra_data),
        .wrb_valid_o(wrb_valid),
        .wrb_addr_o (wrb_addr),
        .wrb_data_o (wrb_data),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // RAM stand-in: records what the write ports commit on each edge.
    always @(posedge clk) begin
        if (wra_valid) begin
            ram_model[wra_addr] = wra_data;
            wa_addr_q.push_back(wra_addr);
            wa_data_q.push_back(wra_data);
            nwrites++;
            if (win_en) src_cnt[wra_addr >> 8]++;
        end
        if (wrb_valid) begin
            ram_model[wrb_addr] = wrb_data;
            nwrites++;
            if (win_en) src_cnt[wrb_addr >> 8]++;
        end
        if (win_en && wra_valid && wrb_valid) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        src_valid[k]          = v;
        src_addr[k*AW +: AW]  = a;
        src_data[k*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0;
        step();
        rst = 1'b0;
        step();
        wa_addr_q.delete();
        wa_data_q.delete();
        nwrites = 0;
    endtask

    initial begin
        int sent;
        int seq [NS];
        logic acc [NS];
        logic acc1;
        logic saw_low;
        bit   done;

        // 1. Reset
        step(); step(); step();
        check_eq("rst_ready", 64'(src_ready), 64'h0);
        check_eq("rst_wra_valid", 64'(wra_valid), 64'h0);
        check_eq("rst_wrb_valid", 64'(wrb_valid), 64'h0);
        check_eq("rst_addr_data", {wra_addr, wrb_addr, 10'h0, wra_data != 0, wrb_data != 0},
                 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        #1;
        check_eq("ready_before_edge", 64'(src_ready), 64'h0);
        step();
        check_eq("ready_after_release", 64'(src_ready), 64'h7);

        // 2. Single write, 2-cycle latency
        set_src(0, 1'b1, 11'h010, 32'hDEADBEEF);
        step();
        src_valid = '0;
        check_eq("single_not_yet", 64'(wra_valid), 64'h0);
        check_eq("single_busy", 64'(busy), 64'h1);
        step();
        check_eq("single_wra_valid", 64'(wra_valid), 64'h1);
        check_eq("single_wra_addr", 64'(wra_addr), 64'h010);
        check_eq("single_wra_data", 64'(wra_data), 64'hDEADBEEF);
        check_eq("single_wrb_valid", 64'(wrb_valid), 64'h0);
        step();
        check_eq("single_one_cycle", 64'(wra_valid), 64'h0);
        check_eq("single_idle", 64'(busy), 64'h0);

        // 3. Dual issue with rr=0
        do_reset();
        set_src(0, 1'b1, 11'h001, 32'h11111111);
        set_src(2, 1'b1, 11'h002, 32'h22222222);
        step();
        src_valid = '0;
        step();
        check_eq("dual_a", {31'h0, wra_valid, 21'h0, wra_addr}, {31'h0, 1'b1, 21'h0, 11'h001});
        check_eq("dual_a_data", 64'(wra_data), 64'h11111111);
        check_eq("dual_b", {31'h0, wrb_valid, 21'h0, wrb_addr}, {31'h0, 1'b1, 21'h0, 11'h002});
        check_eq("dual_b_data", 64'(wrb_data), 64'h22222222);
        step();
        check_eq("dual_done", {wra_valid, wrb_valid}, 64'h0);

        // 4. Address conflict; rr is back at 0 after src2 issued last
        set_src(0, 1'b1, 11'h0AA, 32'h0000000A);
        set_src(1, 1'b1, 11'h0AA, 32'h0000000B);
        step();
        src_valid = '0;
        step();
        check_eq("conf_c1_a", {wra_valid, wra_data}, {1'b1, 32'h0000000A});
        check_eq("conf_c1_b", 64'(wrb_valid), 64'h0);
        step();
        check_eq("conf_c2_a", {wra_valid, wra_addr, wra_data}, {1'b1, 11'h0AA, 32'h0000000B});
        check_eq("conf_c2_b", 64'(wrb_valid), 64'h0);
        step();
        check_eq("conf_ram", 64'(ram_model[11'h0AA]), 64'hB);

        // 5. Single source streaming 0..5
        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
            set_src(1, 1'b1, AW'(sent), 32'h500 + 32'(sent));
            acc1 = src_ready[1];
            step();
            if (acc1) sent++;
        end
        src_valid = '0;
        check_eq("bp_all_sent", 64'(sent), 64'd6);
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (!busy) done = 1'b1;
            else step();
        end
        check_eq("bp_busy_falls", 64'(done), 64'h1);
        check_eq("bp_count", 64'(wa_addr_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("bp_addr%0d", i), 64'(wa_addr_q[i]), 64'(i));
            check_eq($sformatf("bp_data%0d", i), 64'(wa_data_q[i]), 64'h500 + 64'(i));
        end
        check_eq("bp_no_portb", 64'(nwrites), 64'd6);

        // 6. Fairness with all sources saturated, then mid-stream reset
        do_reset();
        for (int k = 0; k < NS; k++) seq[k] = 0;
        for (int k = 0; k < 4; k++) src_cnt[k] = 0;
        saw_low = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc == 6) win_en = 1'b1;
            for (int k = 0; k < NS; k++) begin
                set_src(k, 1'b1, AW'(32'h100 * (k + 1) + seq[k]), 32'(k * 1000 + seq[k]));
                acc[k] = src_ready[k];
            end
            if (win_en && src_ready != 3'b111) saw_low = 1'b1;
            step();
            for (int k = 0; k < NS; k++) if (acc[k]) seq[k]++;
        end
        win_en = 1'b0;
        check_eq("fair_src0", 64'(src_cnt[1]), 64'd6);
        check_eq("fair_src1", 64'(src_cnt[2]), 64'd6);
        check_eq("fair_src2", 64'(src_cnt[3]), 64'd6);
        check_eq("fair_dual_every_cycle", 64'(both_cnt), 64'd9);
        check_eq("fair_backpressure", 64'(saw_low), 64'h1);
        check_eq("midrst_prebusy", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        check_eq("midrst_valids", {wra_valid, wrb_valid}, 64'h0);
        check_eq("midrst_addrs", {wra_addr, wrb_addr}, 64'h0);
        check_eq("midrst_ready_busy", {src_ready, busy}, 64'h0);
        src_valid = '0;
        step();
        nwrites = 0;
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) step();
        check_eq("midrst_no_stale", 64'(nwrites), 64'd0);
        check_eq("midrst_ready_back", 64'(src_ready), 64'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
